// File: rtl/if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_queue
// Purpose  : Instruction-fetch front end for the IF/ID register of the ARM64
//            5-stage pipeline. Issues sequential, in-order fetch requests to
//            instruction memory. Buffers the returned words with their PCs in
//            a DEPTH-entry queue and presents the head entry to IF/ID.
//            A redirect flushes the queue. The responses still in flight at
//            that point are counted and discarded when they arrive.
// Ports    : CLK, resetl (synchronous, active-low), startpc
//            imem_req_valid/addr/ready   - fetch request channel
//            imem_rsp_valid/data         - in-order response channel
//            redirect_valid/pc           - branch/exception redirect from EX
//            id_ready                    - IF/ID accept (0 = stall)
//            if_valid/pc/instr           - head entry presented to IF/ID
//            currentpc                   - next PC to be requested
// Config   : IFQ_BYPASS_EN - when defined, a response that arrives while the
//            queue is empty is presented on if_* in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module if_prefetch_queue #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             CLK,
   input  logic             resetl,
   input  logic [63:0]      startpc,
   output logic             imem_req_valid,
   output logic [63:0]      imem_req_addr,
   input  logic             imem_req_ready,
   input  logic             imem_rsp_valid,
   input  logic [31:0]      imem_rsp_data,
   input  logic             redirect_valid,
   input  logic [63:0]      redirect_pc,
   input  logic             id_ready,
   output logic             if_valid,
   output logic [63:0]      if_pc,
   output logic [31:0]      if_instr,
   output logic [63:0]      currentpc
);

   // Counters must hold the value DEPTH itself, so they get one extra bit.
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] C_DEPTH = DEPTH[CNT_W:0];

   logic [63:0]      fetch_pc_q, fetch_pc_d;
   logic [63:0]      rsp_pc_q, rsp_pc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic             resetl_q, resetl_d;

   logic [63:0]      pc_mem_q    [DEPTH];
   logic [31:0]      instr_mem_q [DEPTH];

   logic [CNT_W:0]   credit_sum;
   logic             req_fire;
   logic             q_empty;
   logic             bypass;
   logic             deq;
   logic             rsp_keep;
   logic             wr_en;
   logic [CNT_W-1:0] outstanding_next;

   // ------------------------------------------------------------------------
   // Request side, head presentation and next-state computation
   // ------------------------------------------------------------------------
   always_comb begin
      // Queued plus in-flight requests may never exceed the storage. The next
      // request is therefore offered only while a slot is guaranteed to exist.
      credit_sum     = {1'b0, count_q} + {1'b0, outstanding_q};
      imem_req_valid = resetl_q & (credit_sum < C_DEPTH);
      imem_req_addr  = fetch_pc_q;
      currentpc      = fetch_pc_q;
      req_fire       = imem_req_valid & imem_req_ready;

      q_empty = (count_q == '0);

`ifdef IFQ_BYPASS_EN
      // This path forwards a fresh word straight to IF/ID. It applies only
      // when nothing older is waiting in the queue and the word is not stale.
      bypass = resetl & q_empty & (drop_q == '0) & ~redirect_valid & imem_rsp_valid;
`else
      bypass = 1'b0;
`endif

      if_valid = ~q_empty | bypass;
      if_pc    = 64'd0;
      if_instr = 32'd0;
      if (!q_empty) begin
         if_pc    = pc_mem_q[rd_ptr_q];
         if_instr = instr_mem_q[rd_ptr_q];
      end else if (bypass) begin
         if_pc    = rsp_pc_q;
         if_instr = imem_rsp_data;
      end

      deq = ~q_empty & id_ready;

      // A kept response is stored unless the bypass already handed it over.
      rsp_keep = imem_rsp_valid & (drop_q == '0) & ~(bypass & id_ready);

      outstanding_next = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

      // Defaults: hold state.
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      count_d       = count_q;
      outstanding_d = outstanding_q;
      drop_d        = drop_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      resetl_d      = resetl;
      wr_en         = 1'b0;

      if (!resetl) begin
         fetch_pc_d    = startpc & ~64'd3;
         rsp_pc_d      = startpc & ~64'd3;
         count_d       = '0;
         outstanding_d = '0;
         drop_d        = '0;
         rd_ptr_d      = '0;
         wr_ptr_d      = '0;
      end else if (redirect_valid) begin
         // Every request still in flight after this edge is from the old
         // stream. That includes one handshaked right now. Any response
         // arriving this cycle is discarded outright.
         fetch_pc_d    = redirect_pc & ~64'd3;
         rsp_pc_d      = redirect_pc & ~64'd3;
         count_d       = '0;
         rd_ptr_d      = '0;
         wr_ptr_d      = '0;
         outstanding_d = outstanding_next;
         drop_d        = outstanding_next;
      end else begin
         outstanding_d = outstanding_next;
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 64'd4;
         end
         if (imem_rsp_valid) begin
            if (drop_q != '0) begin
               drop_d = drop_q - CNT_W'(1);
            end else begin
               rsp_pc_d = rsp_pc_q + 64'd4;
            end
         end
         wr_en = rsp_keep;
         if (rsp_keep) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(rsp_keep) - CNT_W'(deq);
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      resetl_q      <= resetl_d;
   end

   // Entry storage needs no reset; the head is masked by count.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
         instr_mem_q[wr_ptr_q] <= imem_rsp_data;
      end
   end

endmodule
`default_nettype wire
